// File: rtl/gray_codec_pipe.sv
// Single-stage binary<->Gray converter with valid/ready handshake and a Gray-domain step detector.
// Optional transaction counter enabled by defining GRAY_CODEC_TXN_CNT_EN.
module gray_codec_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_step
`ifdef GRAY_CODEC_TXN_CNT_EN
  ,
  output logic [15:0]      txn_cnt
`endif
);

  // Handshake: a word moves across a port only on a rising edge where valid && ready.
  // The output register is a one-deep skid-free stage, so it can take a new word
  // when it is empty or is being drained in the same cycle.
  logic             accept;
  logic [WIDTH-1:0] gray_of_bin;
  logic [WIDTH-1:0] bin_of_gray;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] last_gray;
  logic [WIDTH-1:0] diff;
  logic             have_last;
  logic             one_hot;
  logic             step_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    gray_of_bin = in_data ^ (in_data >> 1);
    bin_of_gray = '0;
    bin_of_gray[WIDTH-1] = in_data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_of_gray[i] = bin_of_gray[i+1] ^ in_data[i];
    end
  end

  // Step detection always works on Gray codes, whichever direction the word travels.
  always_comb begin
    gray_in   = in_mode ? in_data : gray_of_bin;
    result    = in_mode ? bin_of_gray : gray_of_bin;
    diff      = gray_in ^ last_gray;
    one_hot   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    step_next = have_last && one_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
      out_step  <= 1'b0;
      last_gray <= '0;
      have_last <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_mode  <= in_mode;
      out_step  <= step_next;
      last_gray <= gray_in;
      have_last <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAY_CODEC_TXN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt <= 16'h0000;
    end else if (accept) begin
      txn_cnt <= txn_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench for gray_codec_pipe (WIDTH = 4): a driver pushes expected results,
// a negedge monitor checks handshake state every cycle and pops results as they drain.
module tb_gray_codec_pipe;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;
  logic         out_step;
`ifdef GRAY_CODEC_TXN_CNT_EN
  logic [15:0]  txn_cnt;
  logic [15:0]  mdl_cnt = 16'h0000;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  logic [W+1:0] exp_q[$];
  logic         mdl_ov = 1'b0;
  logic         have_last = 1'b0;
  logic [W-1:0] last_g = '0;
  bit           bp_en = 1'b0;

  gray_codec_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_step  (out_step)
`ifdef GRAY_CODEC_TXN_CNT_EN
    ,
    .txn_cnt   (txn_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference conversions, written bit by bit from the code definitions
  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string tag);
    n_vec++;
    n_err++;
    $display("FAIL %s t=%0t", tag, $time);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    have_last = 1'b0;
    last_g = '0;
  endtask

  // driver: offer one word, push its expected result on the cycle it is accepted
  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] exp_d);
    logic [W-1:0] g;
    logic         st;
    int           budget;
    bit           done;
    budget = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_mode = m;
    in_data = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        g  = m ? d : b2g(d);
        st = have_last && ($countones(g ^ last_g) == 1);
        last_g = g;
        have_last = 1'b1;
        exp_q.push_back({st, m, exp_d});
        done = 1'b1;
      end else if (++budget > 100) begin
        fail_now("send_timeout");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_mode = 1'($urandom_range(0, 1));
    in_data = W'($urandom_range(0, (1 << W) - 1));
  endtask

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // monitor / scoreboard: cycle model of the output register
  always @(negedge clk) begin
    logic         acc;
    logic [W+1:0] e;
    chk("in_ready", in_ready, !mdl_ov || out_ready);
    chk("out_valid", out_valid, mdl_ov);
`ifdef GRAY_CODEC_TXN_CNT_EN
    chk("txn_cnt", txn_cnt, mdl_cnt);
`endif
    if (mdl_ov) begin
      if (exp_q.size() == 0) begin
        fail_now("sb_underflow");
      end else begin
        e = exp_q[0];
        chk("out_data", out_data, e[W-1:0]);
        chk("out_mode", out_mode, e[W]);
        chk("out_step", out_step, e[W+1]);
      end
    end
    acc = !rst && in_valid && (!mdl_ov || out_ready);
    if (rst) begin
      mdl_ov = 1'b0;
      exp_q.delete();
`ifdef GRAY_CODEC_TXN_CNT_EN
      mdl_cnt = 16'h0000;
`endif
    end else begin
      if (mdl_ov && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) mdl_ov = 1'b1;
      else if (out_ready) mdl_ov = 1'b0;
`ifdef GRAY_CODEC_TXN_CNT_EN
      if (acc) mdl_cnt = mdl_cnt + 16'h0001;
`endif
    end
  end

  initial begin
    int t;
    logic         m;
    logic [W-1:0] d;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    reset_dut();

    // reset state and ready after reset
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'b0000);
    chk("rst_out_mode", out_mode, 1'b0);
    chk("rst_out_step", out_step, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef GRAY_CODEC_TXN_CNT_EN
    chk("rst_txn_cnt", txn_cnt, 16'h0000);
`endif

    // fixed vectors both directions
    send(1'b0, 4'b0110, 4'b0101);
    send(1'b0, 4'b1111, 4'b1000);
    send(1'b1, 4'b1000, 4'b1111);
    send(1'b1, 4'b0101, 4'b0110);

    // exhaustive round trip
    for (int v = 0; v < 16; v++) begin
      send(1'b0, W'(v), b2g(W'(v)));
      send(1'b1, b2g(W'(v)), W'(v));
    end

    // step detection
    reset_dut();
    send(1'b0, 4'b0010, 4'b0011);
    send(1'b0, 4'b0011, 4'b0010);
    reset_dut();
    send(1'b0, 4'b0000, 4'b0000);
    send(1'b0, 4'b0101, 4'b0111);
    send(1'b0, 4'b0101, 4'b0111);

    // backpressure: held result, then simultaneous accept and drain
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 4'b0110, 4'b0101);
    in_valid = 1'b1;
    in_data = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_data", out_data, 4'b0101);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(1'b0, 4'b0001, 4'b0001);
    chk("thru_out_valid", out_valid, 1'b1);
    chk("thru_out_data", out_data, 4'b0001);

    // reset while a result is held and a word is offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 4'b0011, 4'b0010);
    in_valid = 1'b1;
    in_data = 4'b1111;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    have_last = 1'b0;
    last_g = '0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, 4'b0000);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    send(1'b0, 4'b0001, 4'b0001);

    // random mixed-mode stream with random backpressure
    bp_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      m = 1'($urandom_range(0, 1));
      d = W'($urandom_range(0, 15));
      send(m, d, m ? g2b(d) : b2g(d));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    bp_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;

`ifdef GRAY_CODEC_TXN_CNT_EN
    // counter wrap and no count on held cycles
    reset_dut();
    for (int k = 0; k < 65537; k++) begin
      send(1'b0, W'(k), b2g(W'(k)));
    end
    chk("txn_wrap", txn_cnt, 16'h0001);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 4'b0100, 4'b0110);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("txn_held", txn_cnt, 16'h0002);
    in_valid = 1'b0;
    out_ready = 1'b1;
`endif

    // drain
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
